// File: rtl/core_pkg.sv
// core_pkg: shared types and lane helpers for the memory-access stage
package core_pkg;
    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } mem_op_t;

    typedef struct packed {
        logic [31:0] reg_data;
        logic [31:0] csr_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic [11:0] csr;
        logic        csr_write;
        logic        is_load;
        logic [2:0]  op_type;
        logic [1:0]  off;
        logic        misaligned;
        logic        done;
        logic [31:0] ldata;
    } ma_entry_t;

    function automatic logic is_aligned(logic [2:0] op, logic [1:0] off);
        return op[1:0] == 2'b00 ? 1'b1 : op[1:0] == 2'b01 ? !off[0] : off == 2'b00;
    endfunction

    function automatic logic [3:0] lane_be(logic [2:0] op, logic [1:0] off);
        return op[1:0] == 2'b00 ? 4'b0001 << off : op[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    endfunction

    function automatic logic [31:0] lane_wdata(logic [2:0] op, logic [31:0] d);
        return op[1:0] == 2'b00 ? {4{d[7:0]}} : op[1:0] == 2'b01 ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] load_extend(logic [2:0] op, logic [1:0] off, logic [31:0] ldata);
        logic [31:0] s;
        s = ldata >> {off, 3'b000};
        return op == OP_B  ? {{24{s[7]}}, s[7:0]} :
               op == OP_BU ? {24'b0, s[7:0]} :
               op == OP_H  ? {{16{s[15]}}, s[15:0]} :
               op == OP_HU ? {16'b0, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/core_ma_ooq_fifo.sv
// core_ma_ooq_fifo: in-order completion queue with out-of-band completion by index
module core_ma_ooq_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rest,
    input  logic          push,
    input  ma_entry_t     push_entry,
    input  logic          pop,
    input  logic          cmp,
    input  logic [AW-1:0] cmp_idx,
    input  logic [31:0]   cmp_data,
    output ma_entry_t     head,
    output logic          empty,
    output logic          full,
    output logic          pend,
    output logic [AW-1:0] pend_idx
);
    ma_entry_t     mem_q [DEPTH];
    ma_entry_t     mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    assign head  = mem_q[head_q];
    assign empty = count_q == '0;
    assign full  = count_q == (AW + 1)'(DEPTH);

    // Next queue state: push at tail, pop at head, fill in a load response by index
    always_comb begin
        mem_d   = mem_q;
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (push) mem_d[tail_q] = push_entry;
        if (cmp) begin
            mem_d[cmp_idx].ldata = cmp_data;
            mem_d[cmp_idx].done  = 1'b1;
        end
    end

    // Oldest occupied entry still awaiting data; only aligned loads are ever pushed not-done
    always_comb begin
        pend     = 1'b0;
        pend_idx = head_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((AW + 1)'(i) < count_q && !mem_q[head_q + AW'(i)].done) begin
                pend     = 1'b1;
                pend_idx = head_q + AW'(i);
            end
        end
    end

    // Queue storage and pointers
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/core_ma_ooq.sv
// core_ma_ooq: memory-access stage, Avalon-MM master with in-order completion queue
module core_ma_ooq
    import core_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              em_valid,
    output logic              em_ready,
    input  logic [31:0]       em_reg_data_mem_addr,
    input  logic [31:0]       em_csr_data_mem_data,
    input  logic              em_mem_read,
    input  logic              em_mem_write,
    input  logic [2:0]        em_mem_op_type,
    input  logic [4:0]        em_rd,
    input  logic              em_reg_write,
    input  logic [11:0]       em_csr,
    input  logic              em_csr_write,
    output logic              mw_valid,
    input  logic              mw_ready,
    output logic [31:0]       mw_reg_data,
    output logic [31:0]       mw_csr_data,
    output logic [31:0]       mw_mem_data,
    output logic              mw_mem_data_valid,
    output logic [4:0]        mw_rd,
    output logic              mw_reg_write,
    output logic [11:0]       mw_csr,
    output logic              mw_csr_write,
    output logic              mw_reg_write_sel,
    output logic              mw_misaligned,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [3:0]        avl_byteenable,
    output logic [31:0]       avl_writedata,
    input  logic              avl_waitrequest,
    input  logic [31:0]       avl_readdata,
    input  logic              avl_readdatavalid,
    output logic              err_spurious_rsp
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]    off;
    logic          aligned, mem_issue, full, empty, push, pop, pend, rsp;
    logic          err_spurious_d, err_spurious_q;
    logic [AW-1:0] pend_idx;
    ma_entry_t     entry, head;

    assign off            = em_reg_data_mem_addr[1:0];
    assign aligned        = is_aligned(em_mem_op_type, off);
    assign mem_issue      = (em_mem_read || em_mem_write) && aligned;
    assign em_ready       = !full && !(mem_issue && avl_waitrequest);
    assign push           = em_valid && em_ready;
    assign avl_read       = em_valid && em_mem_read && aligned && !full;
    assign avl_write      = em_valid && em_mem_write && aligned && !full;
    assign avl_address    = {em_reg_data_mem_addr[ADDR_W-1:2], 2'b00};
    assign avl_byteenable = lane_be(em_mem_op_type, off);
    assign avl_writedata  = lane_wdata(em_mem_op_type, em_csr_data_mem_data);

    // Snapshot the accepted op; only aligned loads wait for a bus response
    always_comb begin
        entry            = '0;
        entry.reg_data   = em_reg_data_mem_addr;
        entry.csr_data   = em_csr_data_mem_data;
        entry.rd         = em_rd;
        entry.reg_write  = em_reg_write;
        entry.csr        = em_csr;
        entry.csr_write  = em_csr_write;
        entry.is_load    = em_mem_read;
        entry.op_type    = em_mem_op_type;
        entry.off        = off;
        entry.misaligned = (em_mem_read || em_mem_write) && !aligned;
        entry.done       = !(em_mem_read && aligned);
    end

    assign rsp            = avl_readdatavalid && pend;
    assign pop            = mw_valid && mw_ready;
    assign err_spurious_d = err_spurious_q || (avl_readdatavalid && !pend);

    core_ma_ooq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rest      (rest),
        .push      (push),
        .push_entry(entry),
        .pop       (pop),
        .cmp       (rsp),
        .cmp_idx   (pend_idx),
        .cmp_data  (avl_readdata),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .pend      (pend),
        .pend_idx  (pend_idx)
    );

    assign mw_valid          = !empty && head.done;
    assign mw_reg_data       = head.reg_data;
    assign mw_csr_data       = head.csr_data;
    assign mw_rd             = head.rd;
    assign mw_reg_write      = head.reg_write;
    assign mw_csr            = head.csr;
    assign mw_csr_write      = head.csr_write;
    assign mw_reg_write_sel  = head.is_load;
    assign mw_mem_data       = load_extend(head.op_type, head.off, head.ldata);
    assign mw_mem_data_valid = mw_valid && head.is_load && !head.misaligned;
    assign mw_misaligned     = mw_valid && head.misaligned;
    assign err_spurious_rsp  = err_spurious_q;

    // Sticky flag for a response beat with no outstanding load
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) err_spurious_q <= 1'b0;
        else err_spurious_q <= err_spurious_d;
    end
endmodule

// File: tb/tb_core_ma_ooq.sv
// tb_core_ma_ooq: table vectors, directed corner sequences and a queue-model random run
module tb_core_ma_ooq;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rest;
    logic        em_valid, em_ready, em_mem_read, em_mem_write, em_reg_write, em_csr_write;
    logic [31:0] em_reg_data_mem_addr, em_csr_data_mem_data;
    logic [2:0]  em_mem_op_type;
    logic [4:0]  em_rd, mw_rd;
    logic [11:0] em_csr, mw_csr;
    logic        mw_valid, mw_ready, mw_mem_data_valid, mw_reg_write, mw_csr_write;
    logic        mw_reg_write_sel, mw_misaligned;
    logic [31:0] mw_reg_data, mw_csr_data, mw_mem_data;
    logic [31:0] avl_address, avl_writedata, avl_readdata;
    logic        avl_read, avl_write, avl_waitrequest, avl_readdatavalid, err_spurious_rsp;
    logic [3:0]  avl_byteenable;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    core_ma_ooq #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rest(rest), .em_valid(em_valid), .em_ready(em_ready),
        .em_reg_data_mem_addr(em_reg_data_mem_addr), .em_csr_data_mem_data(em_csr_data_mem_data),
        .em_mem_read(em_mem_read), .em_mem_write(em_mem_write), .em_mem_op_type(em_mem_op_type),
        .em_rd(em_rd), .em_reg_write(em_reg_write), .em_csr(em_csr), .em_csr_write(em_csr_write),
        .mw_valid(mw_valid), .mw_ready(mw_ready), .mw_reg_data(mw_reg_data), .mw_csr_data(mw_csr_data),
        .mw_mem_data(mw_mem_data), .mw_mem_data_valid(mw_mem_data_valid), .mw_rd(mw_rd),
        .mw_reg_write(mw_reg_write), .mw_csr(mw_csr), .mw_csr_write(mw_csr_write),
        .mw_reg_write_sel(mw_reg_write_sel), .mw_misaligned(mw_misaligned),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_byteenable(avl_byteenable), .avl_writedata(avl_writedata),
        .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid), .err_spurious_rsp(err_spurious_rsp)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wr;
    } st_vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [31:0] reg_data;
        logic        is_load;
        logic        mis;
        logic        done;
        logic [2:0]  op;
        int          off;
        logic [31:0] ldata;
    } m_ent_t;

    st_vec_t     st[7];
    ld_vec_t     ld[7];
    m_ent_t      q[$];
    m_ent_t      ne;
    logic [2:0]  ld_ops[5];
    logic        hold, pending, al, issue, e_ready, e_mwv;
    int          k, sz, off;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        em_valid = 0; em_mem_read = 0; em_mem_write = 0; em_mem_op_type = 0;
        em_reg_data_mem_addr = 0; em_csr_data_mem_data = 0; em_rd = 0; em_reg_write = 0;
        em_csr = 0; em_csr_write = 0; avl_waitrequest = 0; avl_readdatavalid = 0; avl_readdata = 0;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        em_valid = 1; em_mem_read = r; em_mem_write = w; em_mem_op_type = op;
        em_reg_data_mem_addr = a; em_csr_data_mem_data = d; em_rd = 5'd3; em_reg_write = 1;
        em_csr = 12'h300; em_csr_write = 0;
    endtask

    function automatic int sz_of(logic [2:0] op);
        return op[1:0] == 2'b00 ? 1 : op[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_ext(logic [2:0] op, int o, logic [31:0] d);
        logic [31:0] v;
        int b;
        v = d >> (8 * o);
        case (op)
            3'b000: begin b = int'(v % 256); return 32'(b >= 128 ? b - 256 : b); end
            3'b100: return v % 256;
            3'b001: begin b = int'(v % 65536); return 32'(b >= 32768 ? b - 65536 : b); end
            3'b101: return v % 65536;
            default: return d;
        endcase
    endfunction

    initial begin
        st[0] = '{3'b000, 32'h1000, 32'h123456AB, 4'b0001, 32'hABABABAB, 1'b1};
        st[1] = '{3'b000, 32'h1003, 32'h123456AB, 4'b1000, 32'hABABABAB, 1'b1};
        st[2] = '{3'b001, 32'h2002, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 1'b1};
        st[3] = '{3'b001, 32'h2000, 32'h1234ABCD, 4'b0011, 32'hABCDABCD, 1'b1};
        st[4] = '{3'b001, 32'h2001, 32'h1234ABCD, 4'b0000, 32'h0,        1'b0};
        st[5] = '{3'b010, 32'h3000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b1};
        st[6] = '{3'b010, 32'h3002, 32'hDEADBEEF, 4'b0000, 32'h0,        1'b0};
        ld[0] = '{3'b000, 32'h1003, 32'h80FFFF00, 32'hFFFFFF80};
        ld[1] = '{3'b100, 32'h1003, 32'h80FFFF00, 32'h00000080};
        ld[2] = '{3'b001, 32'h1002, 32'h80011234, 32'hFFFF8001};
        ld[3] = '{3'b101, 32'h1002, 32'h80011234, 32'h00008001};
        ld[4] = '{3'b001, 32'h1000, 32'h00007FFF, 32'h00007FFF};
        ld[5] = '{3'b010, 32'h1000, 32'hCAFEBABE, 32'hCAFEBABE};
        ld[6] = '{3'b000, 32'h1001, 32'h00007F00, 32'h0000007F};
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        idle(); mw_ready = 1; rest = 0;
        #3;
        chk("rst mw_valid", mw_valid, 0);
        chk("rst mw_reg_data", mw_reg_data, 0);
        chk("rst err", err_spurious_rsp, 0);
        chk("rst em_ready", em_ready, 1);
        chk("rst avl_read", avl_read, 0);
        tick(); rest = 1; tick();

        // back-to-back ALU ops
        drive(0, 0, 3'b000, 32'h11, 32'hA1);
        #2;
        chk("alu bus", {avl_read, avl_write}, 0);
        chk("alu mw_valid0", mw_valid, 0);
        tick(); drive(0, 0, 3'b000, 32'h22, 32'hA2);
        #2;
        chk("alu r1", mw_reg_data, 32'h11);
        chk("alu csr_data", mw_csr_data, 32'hA1);
        chk("alu rd/csr", {mw_rd, mw_reg_write, mw_csr, mw_csr_write}, {5'd3, 1'b1, 12'h300, 1'b0});
        chk("alu sel", mw_reg_write_sel, 0);
        tick(); drive(0, 0, 3'b000, 32'h33, 32'hA3);
        #2;
        chk("alu r2", {mw_valid, mw_reg_data}, {1'b1, 32'h22});
        tick(); idle();
        #2;
        chk("alu r3", {mw_valid, mw_reg_data}, {1'b1, 32'h33});
        tick();
        #2;
        chk("alu drained", mw_valid, 0);

        // store steering table
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, st[i].op, st[i].addr, st[i].data);
            #2;
            chk("st avl_write", avl_write, st[i].wr);
            if (st[i].wr) begin
                chk("st be", avl_byteenable, st[i].be);
                chk("st wdata", avl_writedata, st[i].wdata);
                chk("st addr", avl_address, st[i].addr & 32'hFFFF_FFFC);
            end
            tick(); idle();
            #2;
            chk("st mw_valid", mw_valid, 1);
            chk("st misaligned", mw_misaligned, !st[i].wr);
            chk("st mdv", mw_mem_data_valid, 0);
            tick();
        end

        // load extension table
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, ld[i].op, ld[i].addr, 0);
            #2;
            chk("ld avl_read", avl_read, 1);
            chk("ld addr", avl_address, ld[i].addr & 32'hFFFF_FFFC);
            tick(); idle();
            avl_readdatavalid = 1; avl_readdata = ld[i].rdata;
            #2;
            chk("ld wait", mw_valid, 0);
            tick(); idle();
            #2;
            chk("ld mw_valid", mw_valid, 1);
            chk("ld data", mw_mem_data, ld[i].exp);
            chk("ld sel/mdv", {mw_reg_write_sel, mw_mem_data_valid, mw_misaligned}, 3'b110);
            tick();
        end

        // LW, ADD, LW with waitrequest on the first load
        drive(1, 0, 3'b010, 32'h100, 0); avl_waitrequest = 1;
        #2;
        chk("wr ready0", {em_ready, avl_read}, 2'b01);
        tick();
        #2;
        chk("wr ready1", em_ready, 0);
        tick(); avl_waitrequest = 0;
        #2;
        chk("wr ready2", em_ready, 1);
        tick(); drive(0, 0, 3'b000, 32'hAD, 0);
        #2;
        chk("ord c3", mw_valid, 0);
        tick(); drive(1, 0, 3'b010, 32'h104, 0);
        #2;
        chk("ord c4", mw_valid, 0);
        tick(); idle(); avl_readdatavalid = 1; avl_readdata = 32'h11111111;
        #2;
        chk("ord c5", mw_valid, 0);
        tick(); idle();
        #2;
        chk("ord lw1", {mw_valid, mw_reg_write_sel, mw_mem_data}, {2'b11, 32'h11111111});
        tick(); avl_readdatavalid = 1; avl_readdata = 32'h22222222;
        #2;
        chk("ord add", {mw_valid, mw_reg_write_sel, mw_reg_data}, {2'b10, 32'hAD});
        tick(); idle();
        #2;
        chk("ord lw2", {mw_valid, mw_mem_data, mw_reg_data}, {1'b1, 32'h22222222, 32'h104});
        tick();
        #2;
        chk("ord empty", mw_valid, 0);

        // fill the queue with loads, then drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 3'b010, 32'h400 + 32'(4 * i), 0);
            #2;
            chk("full ready", em_ready, 1);
            tick();
        end
        drive(1, 0, 3'b010, 32'h500, 0);
        #2;
        chk("full block", {em_ready, avl_read, mw_valid}, 3'b000);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); avl_readdatavalid = 1; avl_readdata = 32'hA0 + 32'(i);
            #2;
            if (i > 0) chk("drain data", {mw_valid, mw_mem_data, mw_reg_data},
                           {1'b1, 32'hA0 + 32'(i - 1), 32'h400 + 32'(4 * (i - 1))});
            tick();
        end
        idle();
        #2;
        chk("drain last", {mw_valid, mw_mem_data}, {1'b1, 32'hA3});
        tick();
        #2;
        chk("drain done", {mw_valid, em_ready}, 2'b01);

        // misaligned load: no bus, trap flag next cycle
        drive(1, 0, 3'b010, 32'h3002, 0);
        #2;
        chk("mis bus", {avl_read, em_ready}, 2'b01);
        tick(); idle();
        #2;
        chk("mis flag", {mw_valid, mw_misaligned, mw_mem_data_valid}, 3'b110);
        tick();

        // spurious response, sticky until reset
        avl_readdatavalid = 1; avl_readdata = 32'h5;
        #2;
        chk("sp pre", err_spurious_rsp, 0);
        tick(); idle();
        #2;
        chk("sp set", err_spurious_rsp, 1);
        tick(); tick();
        chk("sp held", err_spurious_rsp, 1);
        drive(1, 0, 3'b010, 32'h600, 0);
        tick(); idle(); rest = 0;
        #1;
        chk("rst mid", {err_spurious_rsp, mw_valid, em_ready}, 3'b001);
        tick(); rest = 1; tick();
        avl_readdatavalid = 1; avl_readdata = 32'h7;
        tick(); idle();
        #2;
        chk("sp after rst", err_spurious_rsp, 1);
        rest = 0; tick(); rest = 1; tick();

        // randomized run against a queue model
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                k = $urandom_range(0, 3);
                em_valid = $urandom_range(0, 4) != 0;
                em_mem_read = (k == 1 || k == 2);
                em_mem_write = (k == 3);
                em_mem_op_type = k == 3 ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
                em_reg_data_mem_addr = $urandom;
                em_csr_data_mem_data = $urandom;
                em_rd = 5'($urandom);
            end
            mw_ready = $urandom_range(0, 3) != 0;
            avl_waitrequest = $urandom_range(0, 2) == 0;
            pending = 0;
            foreach (q[i]) if (!q[i].done) pending = 1;
            avl_readdatavalid = pending && $urandom_range(0, 2) == 0;
            avl_readdata = $urandom;
            off = int'(em_reg_data_mem_addr[1:0]);
            sz = sz_of(em_mem_op_type);
            al = (off % sz) == 0;
            issue = (em_mem_read || em_mem_write) && al;
            e_ready = q.size() < DEPTH && !(issue && avl_waitrequest);
            e_mwv = q.size() > 0 && q[0].done;
            #2;
            chk("rnd em_ready", em_ready, e_ready);
            chk("rnd avl_read", avl_read, em_valid && em_mem_read && al && q.size() < DEPTH);
            chk("rnd avl_write", avl_write, em_valid && em_mem_write && al && q.size() < DEPTH);
            if (avl_write) chk("rnd be", avl_byteenable, 32'(((1 << sz) - 1) << off));
            chk("rnd mw_valid", mw_valid, e_mwv);
            if (e_mwv) begin
                chk("rnd reg_data", mw_reg_data, q[0].reg_data);
                chk("rnd mis", mw_misaligned, q[0].mis);
                chk("rnd mdv", mw_mem_data_valid, q[0].is_load && !q[0].mis);
                if (q[0].is_load && !q[0].mis)
                    chk("rnd mem_data", mw_mem_data, ref_ext(q[0].op, q[0].off, q[0].ldata));
            end
            if (avl_readdatavalid)
                for (int i = 0; i < q.size(); i++)
                    if (!q[i].done) begin
                        q[i].done = 1;
                        q[i].ldata = avl_readdata;
                        break;
                    end
            if (e_mwv && mw_ready) void'(q.pop_front());
            if (em_valid && e_ready) begin
                ne.reg_data = em_reg_data_mem_addr;
                ne.is_load = em_mem_read;
                ne.mis = (em_mem_read || em_mem_write) && !al;
                ne.done = !(em_mem_read && al);
                ne.op = em_mem_op_type;
                ne.off = off;
                ne.ldata = 0;
                q.push_back(ne);
            end
            hold = em_valid && !e_ready;
            tick();
        end
        idle();
        #2;
        chk("rnd no spurious", err_spurious_rsp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
